stack_seq: RTL and testbench

Stack access sequencer for the 8051 core: it turns PUSH, POP, CALL (LCALL/ACALL/interrupt vector) and RET/RETI requests into ordered internal-RAM write/read cycles at stack-pointer addresses. It owns the SP register and exposes it to the SFR read mux. It sits between the instruction decoder/interrupt controller and the internal RAM port.

---
 rtl/stack_seq_pkg.sv | 48 ++++
 rtl/stack_seq_if.sv | 45 ++++
 rtl/stack_seq_ptr_unit.sv | 64 ++++++
 rtl/stack_seq.sv | 172 +++++++++++++++++
 tb/tb_stack_seq.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_seq_pkg
// Purpose  : Stack op codes, FSM state encoding and SP update commands shared
//            by the stack access sequencer and its stack-pointer unit.
// Revision : 1.0 - initial release
// ============================================================================
package stack_seq_pkg;

  // SFR address of the stack pointer (direct MOV target that raises sp_wr)
  localparam logic [7:0] SFR_SP = 8'h81;

  // Stack request codes; 0, 6 and 7 are not stack operations
  localparam logic [2:0] STK_PUSH = 3'd1;
  localparam logic [2:0] STK_POP  = 3'd2;
  localparam logic [2:0] STK_CALL = 3'd3;
  localparam logic [2:0] STK_RET  = 3'd4;
  localparam logic [2:0] STK_RETI = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PUSH_WR = 4'd1,
    ST_POP_RD  = 4'd2,
    ST_POP_CAP = 4'd3,
    ST_CALL_LO = 4'd4,
    ST_CALL_HI = 4'd5,
    ST_RET_HI  = 4'd6,
    ST_RET_LO  = 4'd7,
    ST_RET_CAP = 4'd8
  } stk_state_t;

  // Stack-pointer update command issued by the sequencer each cycle
  typedef enum logic [2:0] {
    SP_HOLD = 3'd0,
    SP_LOAD = 3'd1,
    SP_INC1 = 3'd2,
    SP_INC2 = 3'd3,
    SP_DEC1 = 3'd4,
    SP_DEC2 = 3'd5
  } sp_op_t;

  function automatic logic is_stk_op(input logic [2:0] code);
    return (code == STK_PUSH) || (code == STK_POP) || (code == STK_CALL) ||
           (code == STK_RET)  || (code == STK_RETI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : stack_seq_if
// Purpose  : Request, RAM-port and status bundle of the stack sequencer.
//            master = decoder/interrupt/RAM side, slave = the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface stack_seq_if;
  import stack_seq_pkg::*;

  logic        op_valid;
  logic [2:0]  op_code;
  logic [7:0]  push_data;
  logic [15:0] ret_pc;
  logic        sp_wr;
  logic [7:0]  sp_wdata;
  logic        op_ready;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic        ram_re;
  logic [7:0]  ram_rdata;
  logic        pop_valid;
  logic [7:0]  pop_data;
  logic        pc_load;
  logic [15:0] pc_out;
  logic        reti_done;
  logic        ovf;
  logic        uf;
  logic [7:0]  sp_out;

  modport master (
    output op_valid, op_code, push_data, ret_pc, sp_wr, sp_wdata, ram_rdata,
    input  op_ready, ram_addr, ram_we, ram_wdata, ram_re, pop_valid, pop_data,
           pc_load, pc_out, reti_done, ovf, uf, sp_out
  );

  modport slave (
    input  op_valid, op_code, push_data, ret_pc, sp_wr, sp_wdata, ram_rdata,
    output op_ready, ram_addr, ram_we, ram_wdata, ram_re, pop_valid, pop_data,
           pc_load, pc_out, reti_done, ovf, uf, sp_out
  );

endinterface
`default_nettype wire

// File: rtl/stack_seq_ptr_unit.sv
`default_nettype none
// ============================================================================
// Module   : stack_ptr_unit
// Purpose  : SP register with load / +1 / +2 / -1 / -2 updates, increment
//            wrap detection and floor (underflow) flags.
// Revision : 1.0 - initial release
// ============================================================================
module stack_ptr_unit
  import stack_seq_pkg::*;
#(
  parameter logic [7:0] RST_SP = 8'h07
) (
  input  logic       clock,
  input  logic       reset,
  input  sp_op_t     op,
  input  logic [7:0] load_val,
  output logic [7:0] sp,
  output logic [7:0] sp_inc1,
  output logic [7:0] sp_inc2,
  output logic [7:0] sp_dec1,
  output logic       ovf,
  output logic       at_floor,
  output logic       near_floor
);

  logic [7:0] r_sp;
  logic [8:0] w_inc1;
  logic [8:0] w_inc2;
  logic [8:0] w_floor1;

  assign w_inc1   = {1'b0, r_sp} + 9'd1;
  assign w_inc2   = {1'b0, r_sp} + 9'd2;
  assign w_floor1 = {1'b0, RST_SP} + 9'd1;

  assign sp      = r_sp;
  assign sp_inc1 = w_inc1[7:0];
  assign sp_inc2 = w_inc2[7:0];
  assign sp_dec1 = r_sp - 8'd1;

  // A pop step at or below the reset SP must not decrement
  assign at_floor   = (r_sp <= RST_SP);
  // A two-byte pop from here can only take one decrement
  assign near_floor = ({1'b0, r_sp} <= w_floor1);
  // Carry out of the increment actually being applied this cycle
  assign ovf = ((op == SP_INC1) && w_inc1[8]) || ((op == SP_INC2) && w_inc2[8]);

  // SP register update, modulo 256
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sp <= RST_SP;
    end else begin
      case (op)
        SP_LOAD: r_sp <= load_val;
        SP_INC1: r_sp <= w_inc1[7:0];
        SP_INC2: r_sp <= w_inc2[7:0];
        SP_DEC1: r_sp <= r_sp - 8'd1;
        SP_DEC2: r_sp <= r_sp - 8'd2;
        default: r_sp <= r_sp;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/stack_seq.sv
`default_nettype none
// ============================================================================
// Module   : stack_seq
// Purpose  : 8051 stack access sequencer. Turns PUSH/POP/CALL/RET/RETI into
//            ordered internal-RAM cycles at SP addresses and owns SP.
// Revision : 1.0 - initial release
// ============================================================================
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter logic [7:0] RST_SP = 8'h07
) (
  input logic        clock,
  input logic        reset,
  stack_seq_if.slave bus
);

  stk_state_t  r_state;
  stk_state_t  w_next;
  sp_op_t      w_sp_op;
  logic [7:0]  w_sp, w_sp_inc1, w_sp_inc2, w_sp_dec1;
  logic        w_ovf, w_at_floor, w_near_floor;
  logic [7:0]  r_push_data;
  logic [15:0] r_ret_pc;
  logic [7:0]  r_hi;
  logic        r_is_reti;
  logic        w_ready, w_accept;
  logic [7:0]  w_ram_addr, w_ram_wdata, w_pop_data;
  logic        w_ram_we, w_ram_re, w_pop_valid, w_pc_load, w_reti_done, w_uf;
  logic [15:0] w_pc_out;

  stack_ptr_unit #(.RST_SP(RST_SP)) u_sp (
    .clock      (clock),
    .reset      (reset),
    .op         (w_sp_op),
    .load_val   (bus.sp_wdata),
    .sp         (w_sp),
    .sp_inc1    (w_sp_inc1),
    .sp_inc2    (w_sp_inc2),
    .sp_dec1    (w_sp_dec1),
    .ovf        (w_ovf),
    .at_floor   (w_at_floor),
    .near_floor (w_near_floor)
  );

  // State register, operand capture at accept, RET high-byte holding register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_push_data <= 8'h00;
      r_ret_pc    <= 16'h0000;
      r_is_reti   <= 1'b0;
      r_hi        <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_push_data <= bus.push_data;
        r_ret_pc    <= bus.ret_pc;
        r_is_reti   <= (bus.op_code == STK_RETI);
      end
      if (r_state == ST_RET_LO) r_hi <= bus.ram_rdata;
    end
  end

  // Next state and output decode; RAM-side outputs use registered state/SP only
  always_comb begin
    w_next      = r_state;
    w_sp_op     = SP_HOLD;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_ram_addr  = 8'h00;
    w_ram_we    = 1'b0;
    w_ram_wdata = 8'h00;
    w_ram_re    = 1'b0;
    w_pop_valid = 1'b0;
    w_pop_data  = 8'h00;
    w_pc_load   = 1'b0;
    w_pc_out    = 16'h0000;
    w_reti_done = 1'b0;
    w_uf        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = !bus.sp_wr;
        if (bus.sp_wr) begin
          w_sp_op = SP_LOAD;
        end else if (bus.op_valid && is_stk_op(bus.op_code)) begin
          w_accept = 1'b1;
          case (bus.op_code)
            STK_PUSH: w_next = ST_PUSH_WR;
            STK_POP:  w_next = ST_POP_RD;
            STK_CALL: w_next = ST_CALL_LO;
            default:  w_next = ST_RET_HI;
          endcase
        end
      end
      ST_PUSH_WR: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = w_sp_inc1;
        w_ram_wdata = r_push_data;
        w_sp_op     = SP_INC1;
        w_next      = ST_IDLE;
      end
      ST_POP_RD: begin
        w_ram_re   = 1'b1;
        w_ram_addr = w_sp;
        w_next     = ST_POP_CAP;
      end
      ST_POP_CAP: begin
        w_pop_valid = 1'b1;
        w_pop_data  = bus.ram_rdata;
        if (w_at_floor) w_uf = 1'b1;
        else            w_sp_op = SP_DEC1;
        w_next = ST_IDLE;
      end
      ST_CALL_LO: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = w_sp_inc1;
        w_ram_wdata = r_ret_pc[7:0];
        w_next      = ST_CALL_HI;
      end
      ST_CALL_HI: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = w_sp_inc2;
        w_ram_wdata = r_ret_pc[15:8];
        w_sp_op     = SP_INC2;
        w_next      = ST_IDLE;
      end
      ST_RET_HI: begin
        w_ram_re   = 1'b1;
        w_ram_addr = w_sp;
        w_next     = ST_RET_LO;
      end
      ST_RET_LO: begin
        w_ram_re   = 1'b1;
        w_ram_addr = w_sp_dec1;
        w_next     = ST_RET_CAP;
      end
      ST_RET_CAP: begin
        w_pc_load   = 1'b1;
        w_pc_out    = {r_hi, bus.ram_rdata};
        w_reti_done = r_is_reti;
        // Each of the two pop steps decrements only while above the floor
        if (w_at_floor) begin
          w_uf = 1'b1;
        end else if (w_near_floor) begin
          w_uf    = 1'b1;
          w_sp_op = SP_DEC1;
        end else begin
          w_sp_op = SP_DEC2;
        end
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.op_ready  = w_ready;
  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_we    = w_ram_we;
  assign bus.ram_wdata = w_ram_wdata;
  assign bus.ram_re    = w_ram_re;
  assign bus.pop_valid = w_pop_valid;
  assign bus.pop_data  = w_pop_data;
  assign bus.pc_load   = w_pc_load;
  assign bus.pc_out    = w_pc_out;
  assign bus.reti_done = w_reti_done;
  assign bus.ovf       = w_ovf;
  assign bus.uf        = w_uf;
  assign bus.sp_out    = w_sp;

endmodule
`default_nettype wire

// File: tb/tb_stack_seq.sv
`timescale 1ns/1ps
module tb_stack_seq;
  import stack_seq_pkg::*;

  localparam logic [7:0] RST_SP = 8'h07;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  stack_seq_if bus();
  stack_seq #(.RST_SP(RST_SP)) dut (.clock(clock), .reset(reset), .bus(bus));

  // Internal RAM: synchronous write, read data valid the cycle after ram_re
  logic [7:0] mem [256];
  always @(posedge clock) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: SP value and the stack bytes it knows to be in RAM
  logic [7:0] ref_sp;
  logic [7:0] ref_mem [256];
  bit         ref_known [256];

  // Expected effects of one operation
  int          exp_occ, exp_nwr, exp_nrd, exp_npop, exp_npcl, exp_nreti, exp_novf, exp_nuf;
  logic [7:0]  exp_wa [2];
  logic [7:0]  exp_wd [2];
  logic [7:0]  exp_ra [2];
  logic [7:0]  exp_popd;
  logic [15:0] exp_pc;
  bit          exp_pop_known, exp_pc_known;

  // Observed effects of one operation
  int          obs_occ, obs_nwr, obs_nrd, obs_npop, obs_npcl, obs_nreti, obs_reti_lone, obs_novf, obs_nuf;
  logic [7:0]  obs_wa [4];
  logic [7:0]  obs_wd [4];
  logic [7:0]  obs_ra [4];
  logic [7:0]  obs_popd, obs_sp;
  logic [15:0] obs_pc;

  task automatic model_op(input logic [2:0] code, input logic [7:0] d, input logic [15:0] pc);
    logic [7:0] s, s1, t;
    bit uf;
    s  = ref_sp;
    s1 = s - 8'd1;
    exp_nwr = 0; exp_nrd = 0; exp_npop = 0; exp_npcl = 0; exp_nreti = 0;
    exp_novf = 0; exp_nuf = 0; exp_pop_known = 0; exp_pc_known = 0;
    exp_popd = 8'h00; exp_pc = 16'h0000; exp_occ = 1;
    case (code)
      STK_PUSH: begin
        exp_occ = 2; exp_nwr = 1;
        exp_wa[0] = s + 8'd1; exp_wd[0] = d;
        exp_novf = (s == 8'hFF) ? 1 : 0;
        ref_sp = s + 8'd1;
      end
      STK_POP: begin
        exp_occ = 3; exp_nrd = 1; exp_ra[0] = s; exp_npop = 1;
        exp_pop_known = ref_known[s]; exp_popd = ref_mem[s];
        if (s <= RST_SP) exp_nuf = 1;
        else ref_sp = s - 8'd1;
      end
      STK_CALL: begin
        exp_occ = 3; exp_nwr = 2;
        exp_wa[0] = s + 8'd1; exp_wd[0] = pc[7:0];
        exp_wa[1] = s + 8'd2; exp_wd[1] = pc[15:8];
        exp_novf = (int'(s) + 2 > 255) ? 1 : 0;
        ref_sp = s + 8'd2;
      end
      STK_RET, STK_RETI: begin
        exp_occ = 4; exp_nrd = 2; exp_ra[0] = s; exp_ra[1] = s1;
        exp_npcl = 1; exp_nreti = (code == STK_RETI) ? 1 : 0;
        exp_pc_known = ref_known[s] && ref_known[s1];
        exp_pc = {ref_mem[s], ref_mem[s1]};
        t = s; uf = 0;
        for (int k = 0; k < 2; k++) begin
          if (t > RST_SP) t = t - 8'd1;
          else uf = 1;
        end
        exp_nuf = uf ? 1 : 0;
        ref_sp = t;
      end
      default: exp_occ = 1;
    endcase
    for (int k = 0; k < exp_nwr; k++) begin
      ref_mem[exp_wa[k]]   = exp_wd[k];
      ref_known[exp_wa[k]] = 1'b1;
    end
  endtask

  // Issue one op at the first ready negedge and record everything until ready again
  task automatic run_op(input logic [2:0] code, input logic [7:0] d, input logic [15:0] pc);
    int n;
    obs_nwr = 0; obs_nrd = 0; obs_npop = 0; obs_npcl = 0; obs_nreti = 0;
    obs_reti_lone = 0; obs_novf = 0; obs_nuf = 0; obs_popd = 8'h00; obs_pc = 16'h0000;
    n = 0;
    while (!bus.op_ready && n < 20) begin @(negedge clock); n++; end
    bus.op_valid = 1'b1; bus.op_code = code; bus.push_data = d; bus.ret_pc = pc;
    @(negedge clock);
    bus.op_valid  = 1'b0;
    bus.op_code   = 3'($urandom);
    bus.push_data = 8'($urandom);
    bus.ret_pc    = 16'($urandom);
    obs_occ = 99;
    for (int c = 1; c <= 8; c++) begin
      if (bus.op_ready) begin obs_occ = c; break; end
      if (bus.ram_we) begin
        if (obs_nwr < 4) begin obs_wa[obs_nwr] = bus.ram_addr; obs_wd[obs_nwr] = bus.ram_wdata; end
        obs_nwr++;
      end
      if (bus.ram_re) begin
        if (obs_nrd < 4) obs_ra[obs_nrd] = bus.ram_addr;
        obs_nrd++;
      end
      if (bus.pop_valid) begin obs_npop++; obs_popd = bus.pop_data; end
      if (bus.pc_load)   begin obs_npcl++; obs_pc = bus.pc_out; end
      if (bus.reti_done) begin obs_nreti++; if (!bus.pc_load) obs_reti_lone++; end
      if (bus.ovf) obs_novf++;
      if (bus.uf)  obs_nuf++;
      @(negedge clock);
    end
    obs_sp = bus.sp_out;
  endtask

  task automatic sp_write(input logic [7:0] v);
    bus.sp_wr = 1'b1; bus.sp_wdata = v;
    @(negedge clock);
    bus.sp_wr = 1'b0;
    ref_sp = v;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.push_data = 8'h00; bus.ret_pc = 16'h0000;
    bus.sp_wr = 1'b0; bus.sp_wdata = 8'h00;
    for (int i = 0; i < 256; i++) ref_known[i] = 1'b0;
    ref_sp = RST_SP;
    repeat (3) @(negedge clock);
    n_checks++; if (bus.sp_out !== RST_SP) begin n_fail++; $display("FAIL reset_sp: got %h expected %h", bus.sp_out, RST_SP); end
    n_checks++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.op_ready); end
    n_checks++;
    if ({bus.ram_we, bus.ram_re, bus.pop_valid, bus.pc_load, bus.reti_done, bus.ovf, bus.uf} !== 7'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000000",
        {bus.ram_we, bus.ram_re, bus.pop_valid, bus.pc_load, bus.reti_done, bus.ovf, bus.uf});
    end
    n_checks++;
    if ({bus.ram_addr, bus.ram_wdata, bus.pop_data, bus.pc_out} !== 40'h0) begin
      n_fail++; $display("FAIL reset_data: addr %h wdata %h pop %h pc %h expected all zero",
        bus.ram_addr, bus.ram_wdata, bus.pop_data, bus.pc_out);
    end
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (bus.sp_out !== RST_SP) begin n_fail++; $display("FAIL post_reset_sp: got %h expected %h", bus.sp_out, RST_SP); end
  endtask

  task automatic test_push;
    model_op(STK_PUSH, 8'hA5, 16'h0);
    run_op(STK_PUSH, 8'hA5, 16'h0);
    n_checks++; if (obs_nwr !== 1) begin n_fail++; $display("FAIL push_nwr: got %0d expected 1", obs_nwr); end
    n_checks++; if (obs_wa[0] !== 8'h08) begin n_fail++; $display("FAIL push_addr: got %h expected 08", obs_wa[0]); end
    n_checks++; if (obs_wd[0] !== 8'hA5) begin n_fail++; $display("FAIL push_data: got %h expected a5", obs_wd[0]); end
    n_checks++; if (obs_sp !== 8'h08) begin n_fail++; $display("FAIL push_sp: got %h expected 08", obs_sp); end
    n_checks++; if (obs_occ !== 2) begin n_fail++; $display("FAIL push_occ: got %0d expected 2", obs_occ); end
  endtask

  task automatic test_call;
    sp_write(8'h07);
    model_op(STK_CALL, 8'h00, 16'h1234);
    run_op(STK_CALL, 8'h00, 16'h1234);
    n_checks++; if (obs_nwr !== 2) begin n_fail++; $display("FAIL call_nwr: got %0d expected 2", obs_nwr); end
    n_checks++; if ({obs_wa[0], obs_wd[0]} !== 16'h0834) begin n_fail++; $display("FAIL call_lo: got %h@%h expected 34@08", obs_wd[0], obs_wa[0]); end
    n_checks++; if ({obs_wa[1], obs_wd[1]} !== 16'h0912) begin n_fail++; $display("FAIL call_hi: got %h@%h expected 12@09", obs_wd[1], obs_wa[1]); end
    n_checks++; if (obs_sp !== 8'h09) begin n_fail++; $display("FAIL call_sp: got %h expected 09", obs_sp); end
    n_checks++; if (obs_occ !== 3) begin n_fail++; $display("FAIL call_occ: got %0d expected 3", obs_occ); end
  endtask

  task automatic test_reti;
    model_op(STK_RETI, 8'h00, 16'h0);
    run_op(STK_RETI, 8'h00, 16'h0);
    n_checks++; if ({obs_ra[0], obs_ra[1]} !== 16'h0908 || obs_nrd !== 2) begin n_fail++; $display("FAIL reti_reads: got %0d reads %h,%h expected 09,08", obs_nrd, obs_ra[0], obs_ra[1]); end
    n_checks++; if (obs_npcl !== 1 || obs_pc !== 16'h1234) begin n_fail++; $display("FAIL reti_pc: got %0d loads pc %h expected 1 load pc 1234", obs_npcl, obs_pc); end
    n_checks++; if (obs_nreti !== 1 || obs_reti_lone !== 0) begin n_fail++; $display("FAIL reti_done: got %0d pulses (%0d without pc_load) expected 1 (0)", obs_nreti, obs_reti_lone); end
    n_checks++; if (obs_sp !== 8'h07 || obs_nuf !== 0) begin n_fail++; $display("FAIL reti_sp: got sp %h uf %0d expected sp 07 uf 0", obs_sp, obs_nuf); end
    n_checks++; if (obs_occ !== 4) begin n_fail++; $display("FAIL reti_occ: got %0d expected 4", obs_occ); end
  endtask

  task automatic test_underflow;
    model_op(STK_POP, 8'h00, 16'h0);
    run_op(STK_POP, 8'h00, 16'h0);
    n_checks++; if (obs_nrd !== 1 || obs_ra[0] !== 8'h07) begin n_fail++; $display("FAIL pop_uf_read: got %0d reads at %h expected 1 at 07", obs_nrd, obs_ra[0]); end
    n_checks++; if (obs_nuf !== 1 || obs_npop !== 1) begin n_fail++; $display("FAIL pop_uf_pulse: got uf %0d pop_valid %0d expected 1 1", obs_nuf, obs_npop); end
    n_checks++; if (obs_sp !== 8'h07 || obs_occ !== 3) begin n_fail++; $display("FAIL pop_uf_sp: got sp %h occ %0d expected 07 3", obs_sp, obs_occ); end
    sp_write(8'h08);
    model_op(STK_RET, 8'h00, 16'h0);
    run_op(STK_RET, 8'h00, 16'h0);
    n_checks++; if (obs_sp !== 8'h07 || obs_nuf !== 1) begin n_fail++; $display("FAIL ret_uf: got sp %h uf %0d expected 07 1", obs_sp, obs_nuf); end
    n_checks++; if (obs_nreti !== 0 || obs_npcl !== 1) begin n_fail++; $display("FAIL ret_pulses: got reti %0d pc_load %0d expected 0 1", obs_nreti, obs_npcl); end
  endtask

  task automatic test_ovf;
    sp_write(8'hFF);
    model_op(STK_PUSH, 8'h5A, 16'h0);
    run_op(STK_PUSH, 8'h5A, 16'h0);
    n_checks++; if (obs_wa[0] !== 8'h00 || obs_wd[0] !== 8'h5A) begin n_fail++; $display("FAIL ovf_write: got %h@%h expected 5a@00", obs_wd[0], obs_wa[0]); end
    n_checks++; if (obs_novf !== 1) begin n_fail++; $display("FAIL ovf_pulse: got %0d expected 1", obs_novf); end
    n_checks++; if (obs_sp !== 8'h00) begin n_fail++; $display("FAIL ovf_sp: got %h expected 00", obs_sp); end
    model_op(STK_POP, 8'h00, 16'h0);
    run_op(STK_POP, 8'h00, 16'h0);
    n_checks++; if (obs_popd !== 8'h5A || obs_nuf !== 1 || obs_sp !== 8'h00) begin n_fail++; $display("FAIL pop_at_00: got data %h uf %0d sp %h expected 5a 1 00", obs_popd, obs_nuf, obs_sp); end
  endtask

  task automatic test_sp_wr;
    int nwe;
    bus.sp_wr = 1'b1; bus.sp_wdata = 8'h40; bus.op_valid = 1'b1; bus.op_code = STK_PUSH;
    #1;
    n_checks++; if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL spwr_ready: got %b expected 0", bus.op_ready); end
    @(negedge clock);
    bus.sp_wr = 1'b0; bus.op_valid = 1'b0;
    ref_sp = 8'h40;
    nwe = 0;
    repeat (2) begin if (bus.ram_we) nwe++; @(negedge clock); end
    n_checks++; if (bus.sp_out !== 8'h40 || nwe !== 0) begin n_fail++; $display("FAIL spwr_load: got sp %h writes %0d expected 40 0", bus.sp_out, nwe); end
    // sp_wr arriving while busy must be ignored
    bus.op_valid = 1'b1; bus.op_code = STK_PUSH; bus.push_data = 8'h11;
    @(negedge clock);
    bus.op_valid = 1'b0; bus.sp_wr = 1'b1; bus.sp_wdata = 8'hC3;
    @(negedge clock);
    bus.sp_wr = 1'b0;
    model_op(STK_PUSH, 8'h11, 16'h0);
    n_checks++; if (bus.sp_out !== 8'h41) begin n_fail++; $display("FAIL spwr_busy: got sp %h expected 41", bus.sp_out); end
  endtask

  task automatic test_unknown;
    logic [2:0] codes [3];
    int nstb;
    codes[0] = 3'd0; codes[1] = 3'd6; codes[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      bus.op_valid = 1'b1; bus.op_code = codes[i];
      @(negedge clock);
      bus.op_valid = 1'b0;
      nstb = 0;
      repeat (3) begin
        if (bus.ram_we || bus.ram_re || bus.pop_valid || bus.pc_load || !bus.op_ready) nstb++;
        @(negedge clock);
      end
      n_checks++; if (nstb !== 0 || bus.sp_out !== ref_sp) begin n_fail++; $display("FAIL unknown_op %0d: busy/strobe cycles %0d sp %h expected 0 and sp %h", codes[i], nstb, bus.sp_out, ref_sp); end
    end
  endtask

  task automatic test_back_to_back_random;
    logic [2:0] code;
    logic [7:0] d, v;
    logic [15:0] pc;
    int r;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clock);
      r = $urandom_range(0, 99);
      if (r < 6) begin
        case ($urandom_range(0, 3))
          0: v = RST_SP;
          1: v = RST_SP + 8'd1;
          2: v = 8'hFE;
          default: v = 8'($urandom);
        endcase
        sp_write(v);
        continue;
      end
      code = (r < 38) ? STK_PUSH : (r < 58) ? STK_POP : (r < 78) ? STK_CALL : (r < 89) ? STK_RET : STK_RETI;
      d = 8'($urandom); pc = 16'($urandom);
      model_op(code, d, pc);
      run_op(code, d, pc);
      n_checks++; if (obs_occ !== exp_occ) begin n_fail++; $display("FAIL rnd%0d occ: got %0d expected %0d", i, obs_occ, exp_occ); end
      n_checks++; if (obs_sp !== ref_sp) begin n_fail++; $display("FAIL rnd%0d sp: got %h expected %h", i, obs_sp, ref_sp); end
      n_checks++; if (obs_nwr !== exp_nwr || obs_nrd !== exp_nrd) begin n_fail++; $display("FAIL rnd%0d counts: got wr %0d rd %0d expected %0d %0d", i, obs_nwr, obs_nrd, exp_nwr, exp_nrd); end
      for (int k = 0; k < exp_nwr && k < obs_nwr; k++) begin
        n_checks++; if (obs_wa[k] !== exp_wa[k] || obs_wd[k] !== exp_wd[k]) begin n_fail++; $display("FAIL rnd%0d write%0d: got %h@%h expected %h@%h", i, k, obs_wd[k], obs_wa[k], exp_wd[k], exp_wa[k]); end
      end
      for (int k = 0; k < exp_nrd && k < obs_nrd; k++) begin
        n_checks++; if (obs_ra[k] !== exp_ra[k]) begin n_fail++; $display("FAIL rnd%0d read%0d: got %h expected %h", i, k, obs_ra[k], exp_ra[k]); end
      end
      n_checks++; if (obs_npop !== exp_npop || obs_npcl !== exp_npcl || obs_nreti !== exp_nreti || obs_reti_lone !== 0) begin
        n_fail++; $display("FAIL rnd%0d pulses: got pop %0d pcl %0d reti %0d lone %0d expected %0d %0d %0d 0", i, obs_npop, obs_npcl, obs_nreti, obs_reti_lone, exp_npop, exp_npcl, exp_nreti);
      end
      n_checks++; if (obs_novf !== exp_novf || obs_nuf !== exp_nuf) begin n_fail++; $display("FAIL rnd%0d flags: got ovf %0d uf %0d expected %0d %0d", i, obs_novf, obs_nuf, exp_novf, exp_nuf); end
      if (exp_pop_known) begin
        n_checks++; if (obs_popd !== exp_popd) begin n_fail++; $display("FAIL rnd%0d pop_data: got %h expected %h", i, obs_popd, exp_popd); end
      end
      if (exp_pc_known) begin
        n_checks++; if (obs_pc !== exp_pc) begin n_fail++; $display("FAIL rnd%0d pc_out: got %h expected %h", i, obs_pc, exp_pc); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int nwe;
    sp_write(8'h20);
    bus.op_valid = 1'b1; bus.op_code = STK_CALL; bus.ret_pc = 16'hBEEF;
    @(negedge clock);
    bus.op_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h22 || bus.ram_wdata !== 8'hBE) begin
      n_fail++; $display("FAIL mid_call_hi: got we %b %h@%h expected 1 be@22", bus.ram_we, bus.ram_wdata, bus.ram_addr);
    end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.ram_we !== 1'b0 || bus.op_ready !== 1'b1 || bus.sp_out !== RST_SP) begin
      n_fail++; $display("FAIL mid_reset: got we %b ready %b sp %h expected 0 1 %h", bus.ram_we, bus.op_ready, bus.sp_out, RST_SP);
    end
    nwe = 0;
    repeat (2) begin @(negedge clock); if (bus.ram_we) nwe++; end
    reset = 1'b1;
    repeat (2) begin @(negedge clock); if (bus.ram_we) nwe++; end
    n_checks++; if (nwe !== 0 || bus.sp_out !== RST_SP || bus.op_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_recover: got writes %0d sp %h ready %b expected 0 %h 1", nwe, bus.sp_out, bus.op_ready, RST_SP);
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_call();
    test_reti();
    test_underflow();
    test_ovf();
    test_sp_wr();
    test_unknown();
    test_back_to_back_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
